// File: rtl/timer_pkg.sv
// Shared constants and the per-digit limit helper for the BCD cook timer.
// The timer and its digit cells both import this package.
package timer_pkg;

    localparam int              DIGIT_W      = 4;
    localparam logic [3:0]      BCD_MAX      = 4'd9;
    localparam logic [3:0]      SEC_TENS_MAX = 4'd5;

    // Digit 1 holds tens of seconds in MM:SS mode; every other digit is plain decimal.
    function automatic logic [DIGIT_W-1:0] digit_max(input int idx, input bit mmss);
        if (mmss && (idx == 32'sd1)) begin
            return SEC_TENS_MAX;
        end else begin
            return BCD_MAX;
        end
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit with a saturating preset load and a decrement that borrows
// to MAX when the digit is already 0.
module bcd_digit_dec
    import timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = BCD_MAX
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               load,
    input  logic [DIGIT_W-1:0] din,
    input  logic               dec,
    output logic [DIGIT_W-1:0] q,
    output logic               is_zero
);

    logic [DIGIT_W-1:0] q_r;
    logic [DIGIT_W-1:0] load_val_s;

    // Out-of-range preset digits saturate to this digit's maximum.
    always_comb begin
        load_val_s = din;
        if (din > MAX) begin
            load_val_s = MAX;
        end else begin
            load_val_s = din;
        end
    end

    // Digit register: clear, then load, then decrement with borrow.
    always_ff @(posedge clock) begin
        if (clear) begin
            q_r <= 4'd0;
        end else if (load) begin
            q_r <= load_val_s;
        end else if (dec) begin
            q_r <= (q_r == 4'd0) ? MAX : (q_r - 4'd1);
        end else begin
            q_r <= q_r;
        end
    end

    assign q       = q_r;
    assign is_zero = (q_r == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down-counter for the cook timer: preset load, start/stop,
// hold at zero and a one-cycle done pulse when ticking reaches zero.
module bcd_down_timer
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter bit MMSS_MODE  = 1'b1
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic                          enable,
    input  logic                          loadn,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] data_in,
    input  logic                          start,
    input  logic                          stop,
    output logic [DIGIT_W*NUM_DIGITS-1:0] data_out,
    output logic                          running,
    output logic                          zero,
    output logic                          done
);

    localparam int W = DIGIT_W * NUM_DIGITS;

    logic                  load_s;
    logic                  tick_ok_s;
    logic                  terminal_s;
    logic                  zero_s;
    logic                  one_s;
    logic                  running_next_s;
    logic                  running_r;
    logic                  done_r;
    logic [NUM_DIGITS-1:0] is_zero_s;
    logic [NUM_DIGITS-1:0] dec_s;
    logic [NUM_DIGITS:0]   lower_zero_s;

    assign load_s = ~loadn;
    assign zero_s = &is_zero_s;
    assign one_s  = (data_out == {{(W-1){1'b0}}, 1'b1});

    // A tick is lost whenever a higher-priority request shares its cycle.
    assign tick_ok_s  = enable & running_r & ~load_s & ~stop & ~start & ~zero_s;
    assign terminal_s = tick_ok_s & one_s;

    assign lower_zero_s[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < NUM_DIGITS; i++) begin : g_digit
            assign lower_zero_s[i+1] = lower_zero_s[i] & is_zero_s[i];
            assign dec_s[i]          = tick_ok_s & lower_zero_s[i];

            bcd_digit_dec #(
                .MAX (digit_max(i, MMSS_MODE))
            ) u_digit (
                .clock   (clock),
                .clear   (clear),
                .load    (load_s),
                .din     (data_in[DIGIT_W*i +: DIGIT_W]),
                .dec     (dec_s[i]),
                .q       (data_out[DIGIT_W*i +: DIGIT_W]),
                .is_zero (is_zero_s[i])
            );
        end
    endgenerate

    // Run-state next value: load > stop > start > terminal tick.
    always_comb begin
        running_next_s = running_r;
        if (load_s) begin
            running_next_s = 1'b0;
        end else if (stop) begin
            running_next_s = 1'b0;
        end else if (start && !zero_s) begin
            running_next_s = 1'b1;
        end else if (terminal_s) begin
            running_next_s = 1'b0;
        end else begin
            running_next_s = running_r;
        end
    end

    // Control registers; done is high only on the cycle after the final tick.
    always_ff @(posedge clock) begin
        if (clear) begin
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            running_r <= running_next_s;
            done_r    <= terminal_s;
        end
    end

    assign running = running_r;
    assign done    = done_r;
    assign zero    = zero_s;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench for bcd_down_timer: an MM:SS instance and a plain-decimal
// instance share stimulus; expectations are queued per cycle and compared after it.
module tb_bcd_down_timer;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        enable = 1'b0;
    logic        loadn = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic        start = 1'b0;
    logic        stop = 1'b0;

    logic [15:0] data_out, data_out0;
    logic        running, zero, done;
    logic        running0, zero0, done0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [18:0] st;     // {data_out, running, done, zero}
        logic        chk0;
        logic [15:0] d0;
    } ent_t;

    ent_t exp_q[$];
    ent_t obs_q[$];

    always #5 clock = ~clock;

    bcd_down_timer #(.NUM_DIGITS(4), .MMSS_MODE(1'b1)) dut (
        .clock(clock), .clear(clear), .enable(enable), .loadn(loadn),
        .data_in(data_in), .start(start), .stop(stop),
        .data_out(data_out), .running(running), .zero(zero), .done(done)
    );

    bcd_down_timer #(.NUM_DIGITS(4), .MMSS_MODE(1'b0)) dut0 (
        .clock(clock), .clear(clear), .enable(enable), .loadn(loadn),
        .data_in(data_in), .start(start), .stop(stop),
        .data_out(data_out0), .running(running0), .zero(zero0), .done(done0)
    );

    // One cycle of stimulus; outputs are captured 1 time unit after the edge.
    task automatic drive(input logic clr, input logic ldn, input logic [15:0] din,
                         input logic st, input logic sp, input logic en);
        ent_t o;
        @(negedge clock);
        clear = clr; loadn = ldn; data_in = din; start = st; stop = sp; enable = en;
        @(posedge clock);
        #1;
        o.tag  = "obs";
        o.st   = {data_out, running, done, zero};
        o.chk0 = 1'b1;
        o.d0   = data_out0;
        obs_q.push_back(o);
    endtask

    task automatic want(input string tag, input logic [15:0] d, input logic r,
                        input logic dn, input logic z, input logic c0, input logic [15:0] d0);
        ent_t e;
        e.tag = tag; e.st = {d, r, dn, z}; e.chk0 = c0; e.d0 = d0;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        ent_t e, o;
        want("reset", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        drive(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        want("clear_over_load", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        drive(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.st !== e.st) begin
                bad++;
                $display("FAIL %s {data,run,done,zero} got=%h want=%h", e.tag, o.st, e.st);
            end
        end
    endtask

    task automatic test_count();
        ent_t e, o;
        want("load_0130", 16'h0130, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0130);
        drive(1'b0, 1'b0, 16'h0130, 1'b0, 1'b0, 1'b0);
        want("start_0130", 16'h0130, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0130);
        drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        want("tick_0129", 16'h0129, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0129);
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        want("no_tick_hold", 16'h0129, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0129);
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        want("load_0100", 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100);
        drive(1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        want("start_0100", 16'h0100, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0100);
        drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        want("borrow_0100", 16'h0059, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0099);
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        want("load_1000", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1000);
        drive(1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        want("start_1000", 16'h1000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1000);
        drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        want("borrow_1000", 16'h0959, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0999);
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.st !== e.st) begin
                bad++;
                $display("FAIL %s {data,run,done,zero} got=%h want=%h", e.tag, o.st, e.st);
            end
            if (e.chk0) begin
                total++;
                if (o.d0 !== e.d0) begin
                    bad++;
                    $display("FAIL %s decimal data_out got=%h want=%h", e.tag, o.d0, e.d0);
                end
            end
        end
    endtask

    task automatic test_clamp();
        ent_t e, o;
        want("clamp_ffff", 16'h9959, 1'b0, 1'b0, 1'b0, 1'b1, 16'h9999);
        drive(1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        want("clamp_0099", 16'h0059, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0099);
        drive(1'b0, 1'b0, 16'h0099, 1'b0, 1'b0, 1'b0);
        want("load_0000", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        want("start_at_zero", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.st !== e.st) begin
                bad++;
                $display("FAIL %s {data,run,done,zero} got=%h want=%h", e.tag, o.st, e.st);
            end
            if (e.chk0) begin
                total++;
                if (o.d0 !== e.d0) begin
                    bad++;
                    $display("FAIL %s decimal data_out got=%h want=%h", e.tag, o.d0, e.d0);
                end
            end
        end
    endtask

    task automatic test_terminal();
        ent_t e, o;
        want("load_0001", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001);
        drive(1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
        want("start_0001", 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001);
        drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        want("terminal", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        want("done_drops", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        want("tick_at_zero", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        want("start_tick_zero", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.st !== e.st) begin
                bad++;
                $display("FAIL %s {data,run,done,zero} got=%h want=%h", e.tag, o.st, e.st);
            end
        end
    endtask

    task automatic test_stop_start();
        ent_t e, o;
        want("load_0042", 16'h0042, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0042);
        drive(1'b0, 1'b0, 16'h0042, 1'b0, 1'b0, 1'b0);
        want("start_0042", 16'h0042, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0042);
        drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        want("stop_tick", 16'h0042, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0042);
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
        want("tick_stopped", 16'h0042, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0042);
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        want("resume", 16'h0042, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0042);
        drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        want("tick_0041", 16'h0041, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0041);
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        want("start_and_stop", 16'h0041, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0041);
        drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        want("tick_after_ss", 16'h0041, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0041);
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.st !== e.st) begin
                bad++;
                $display("FAIL %s {data,run,done,zero} got=%h want=%h", e.tag, o.st, e.st);
            end
        end
    endtask

    task automatic test_interrupt();
        ent_t e, o;
        want("load_0042b", 16'h0042, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0042);
        drive(1'b0, 1'b0, 16'h0042, 1'b0, 1'b0, 1'b0);
        want("start_0042b", 16'h0042, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0042);
        drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        want("clear_mid_run", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        drive(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        want("load_0042c", 16'h0042, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0042);
        drive(1'b0, 1'b0, 16'h0042, 1'b0, 1'b0, 1'b0);
        want("start_0042c", 16'h0042, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0042);
        drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        want("load_mid_run", 16'h0315, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0315);
        drive(1'b0, 1'b0, 16'h0315, 1'b1, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.st !== e.st) begin
                bad++;
                $display("FAIL %s {data,run,done,zero} got=%h want=%h", e.tag, o.st, e.st);
            end
        end
    endtask

    task automatic test_back_to_back();
        ent_t e, o;
        want("load_0005", 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005);
        drive(1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);
        want("start_with_tick", 16'h0005, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0005);
        drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        for (int k = 4; k >= 1; k--) begin
            want($sformatf("b2b_%0d", k), 16'(k), 1'b1, 1'b0, 1'b0, 1'b1, 16'(k));
            drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        end
        want("b2b_terminal", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        want("b2b_after", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.st !== e.st) begin
                bad++;
                $display("FAIL %s {data,run,done,zero} got=%h want=%h", e.tag, o.st, e.st);
            end
            if (e.chk0) begin
                total++;
                if (o.d0 !== e.d0) begin
                    bad++;
                    $display("FAIL %s decimal data_out got=%h want=%h", e.tag, o.d0, e.d0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_clamp();
        test_terminal();
        test_stop_start();
        test_interrupt();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
